// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// NREQ requesters. The winning request is registered and presented on
// we3/a3/wd3 for exactly one cycle; read addresses that hit the write in
// flight are flagged on hz1/hz2.
module regfile_wr_arbiter #(
  parameter  int NREQ = 4,
  parameter  int AW   = 5,
  parameter  int DW   = 32,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic [AW-1:0]        a1,
  input  logic [AW-1:0]        a2,
  output logic                 we3,
  output logic [AW-1:0]        a3,
  output logic [DW-1:0]        wd3,
  output logic [IDW-1:0]       gnt_id,
  output logic                 hz1,
  output logic                 hz2
);

  typedef enum logic {
    IDLE = 1'b0,
    WR   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   a3_q, a3_d;
  logic [DW-1:0]   wd3_q, wd3_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  int unsigned     idx;
  logic [IDW-1:0]  idx_w;

  // Round-robin search starting at rr_ptr; grants suppressed by stall or reset
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    idx_w   = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      idx   = (32'(rr_ptr_q) + j) % NREQ;
      idx_w = IDW'(idx);
      if (!gnt_vld && req_valid[idx_w]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx_w;
      end
    end
    if (stall || !rst_n) begin
      gnt_vld = 1'b0;
    end
  end

  // One-hot ready for the winner; independent of the output-stage state
  always_comb begin
    req_ready = '0;
    if (gnt_vld) begin
      req_ready = NREQ'(1) << gnt_idx;
    end
  end

  // Next-state: capture the winner, or drop we3 and hold the last write fields
  always_comb begin
    state_d  = IDLE;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    gnt_id_d = gnt_id_q;
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      state_d  = WR;
      a3_d     = req_addr[gnt_idx*AW +: AW];
      wd3_d    = req_data[gnt_idx*DW +: DW];
      gnt_id_d = gnt_idx;
      rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Output stage and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a3_q     <= '0;
      wd3_q    <= '0;
      gnt_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign we3    = (state_q == WR);
  assign a3     = a3_q;
  assign wd3    = wd3_q;
  assign gnt_id = gnt_id_q;
  assign hz1    = we3 & (a1 == a3_q);
  assign hz2    = we3 & (a2 == a3_q);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus a
// randomized run against a behavioural round-robin model.
module tb_regfile_wr_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 stall;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [AW-1:0]        a1, a2, a3;
  logic                 we3;
  logic [DW-1:0]        wd3;
  logic [IDW-1:0]       gnt_id;
  logic                 hz1, hz2;

  int checks = 0;
  int errors = 0;

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .a1(a1), .a2(a2),
    .we3(we3), .a3(a3), .wd3(wd3), .gnt_id(gnt_id), .hz1(hz1), .hz2(hz2)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT write port
  logic [DW-1:0] rf [32];
  always @(posedge clk) if (we3) rf[a3] <= wd3;

  // Requester stimulus (valid is cleared by the model on acceptance)
  bit            s_valid [NREQ];
  logic [AW-1:0] s_addr  [NREQ];
  logic [DW-1:0] s_data  [NREQ];

  // Reference model state
  int unsigned    m_ptr;
  bit             m_we;
  logic [AW-1:0]  m_a;
  logic [DW-1:0]  m_d;
  logic [IDW-1:0] m_id;

  // Expected / observed values of the most recent cycle
  logic [NREQ-1:0] exp_ready, obs_ready;
  bit              exp_hz1, exp_hz2;
  logic            obs_hz1, obs_hz2, obs_we;
  logic [AW-1:0]   obs_a;
  logic [DW-1:0]   obs_d;
  logic [IDW-1:0]  obs_id;

  task automatic model_reset();
    m_ptr = 0; m_we = 0; m_a = '0; m_d = '0; m_id = '0;
    for (int i = 0; i < NREQ; i++) s_valid[i] = 0;
  endtask

  // Drive one cycle of stimulus, predict, and capture DUT values.
  // Entered and left at posedge+1.
  task automatic run_cycle(input bit st, input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    int win;
    win = -1;
    stall = st; a1 = ra1; a2 = ra2;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = s_valid[i];
      req_addr[i*AW +: AW]   = s_addr[i];
      req_data[i*DW +: DW]   = s_data[i];
    end
    if (!st) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = int'((m_ptr + k) % NREQ);
        if (win < 0 && s_valid[c]) win = c;
      end
    end
    exp_ready = (win >= 0) ? (NREQ'(1) << win) : '0;
    exp_hz1 = m_we && (ra1 == m_a);
    exp_hz2 = m_we && (ra2 == m_a);
    @(negedge clk);
    obs_ready = req_ready; obs_hz1 = hz1; obs_hz2 = hz2;
    @(posedge clk);
    if (win >= 0) begin
      m_we = 1; m_a = s_addr[win]; m_d = s_data[win]; m_id = IDW'(win);
      m_ptr = (win + 1) % NREQ;
      s_valid[win] = 0;
    end else begin
      m_we = 0;
    end
    #1;
    obs_we = we3; obs_a = a3; obs_d = wd3; obs_id = gnt_id;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; a1 = '0; a2 = '0;
    req_valid = '1; req_addr = '0; req_data = '1;
    model_reset();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got %b exp 0", we3); end
    checks++; if ({a3, wd3, gnt_id} !== '0) begin errors++; $display("FAIL reset_fields got a3=%0d wd3=%0h id=%0d exp 0", a3, wd3, gnt_id); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (we3 !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL reset_held got we3=%b ready=%b exp 0/0000", we3, req_ready); end
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        s_valid[i] = 1; s_addr[i] = AW'(i + 4*c); s_data[i] = DW'(100*c + i);
      end
      run_cycle(0, '0, '0);
      checks++; if (obs_ready !== (4'b0001 << (c % 4))) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", c, obs_ready, 4'b0001 << (c % 4)); end
      checks++; if (obs_we !== 1'b1 || obs_id !== IDW'(c % 4)) begin errors++; $display("FAIL rr_write[%0d] got we3=%b id=%0d exp 1/%0d", c, obs_we, obs_id, c % 4); end
      checks++; if (obs_a !== m_a || obs_d !== m_d) begin errors++; $display("FAIL rr_data[%0d] got %0d/%0h exp %0d/%0h", c, obs_a, obs_d, m_a, m_d); end
    end
    for (int i = 0; i < NREQ; i++) s_valid[i] = 0;
    run_cycle(0, '0, '0);
    checks++; if (obs_we !== 1'b0 || obs_ready !== 4'b0000) begin errors++; $display("FAIL rr_drain got we3=%b ready=%b exp 0/0000", obs_we, obs_ready); end
  endtask

  task automatic test_single();
    s_valid[0] = 1; s_addr[0] = 5'd9; s_data[0] = 32'd1;
    run_cycle(0, '0, '0);
    checks++; if (obs_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", obs_ready); end
    checks++; if (obs_we !== 1'b1 || obs_a !== 5'd9 || obs_d !== 32'd1 || obs_id !== 2'd0) begin
      errors++; $display("FAIL single_write got we3=%b a3=%0d wd3=%0h id=%0d exp 1/9/1/0", obs_we, obs_a, obs_d, obs_id); end
    run_cycle(0, 5'd9, 5'd0);
    checks++; if (obs_hz1 !== exp_hz1 || obs_hz1 !== 1'b1) begin errors++; $display("FAIL single_hz1 got %b exp 1", obs_hz1); end
    checks++; if (obs_we !== 1'b0 || obs_a !== 5'd9 || obs_d !== 32'd1) begin
      errors++; $display("FAIL single_hold got we3=%b a3=%0d wd3=%0h exp 0/9/1", obs_we, obs_a, obs_d); end
    checks++; if (rf[a1] !== 32'd1) begin errors++; $display("FAIL single_rd1 got %0h exp 1", rf[a1]); end
  endtask

  task automatic test_wrap_skip();
    s_valid[3] = 1; s_addr[3] = 5'd3; s_data[3] = 32'h33;
    run_cycle(0, '0, '0);
    checks++; if (obs_ready !== 4'b1000 || obs_id !== 2'd3) begin errors++; $display("FAIL wrap_first got ready=%b id=%0d exp 1000/3", obs_ready, obs_id); end
    s_valid[0] = 1; s_addr[0] = 5'd10; s_data[0] = 32'hA0;
    s_valid[2] = 1; s_addr[2] = 5'd12; s_data[2] = 32'hA2;
    run_cycle(0, '0, '0);
    checks++; if (obs_ready !== 4'b0001 || obs_id !== 2'd0 || obs_d !== 32'hA0) begin errors++; $display("FAIL wrap_to0 got ready=%b id=%0d wd3=%0h exp 0001/0/a0", obs_ready, obs_id, obs_d); end
    run_cycle(0, '0, '0);
    checks++; if (obs_ready !== 4'b0100 || obs_id !== 2'd2 || obs_a !== 5'd12) begin errors++; $display("FAIL skip_to2 got ready=%b id=%0d a3=%0d exp 0100/2/12", obs_ready, obs_id, obs_a); end
  endtask

  task automatic test_stall();
    run_cycle(0, '0, '0);
    s_valid[1] = 1; s_addr[1] = 5'd17; s_data[1] = 32'h1717;
    for (int c = 0; c < 3; c++) begin
      run_cycle(1, '0, '0);
      checks++; if (obs_ready !== 4'b0000 || obs_we !== 1'b0) begin errors++; $display("FAIL stall_block[%0d] got ready=%b we3=%b exp 0000/0", c, obs_ready, obs_we); end
    end
    run_cycle(0, '0, '0);
    checks++; if (obs_ready !== 4'b0010 || obs_we !== 1'b1 || obs_id !== 2'd1 || obs_a !== 5'd17) begin
      errors++; $display("FAIL stall_release got ready=%b we3=%b id=%0d a3=%0d exp 0010/1/1/17", obs_ready, obs_we, obs_id, obs_a); end
    // A write already in flight completes while stalled
    run_cycle(1, '0, '0);
    checks++; if (obs_ready !== 4'b0000 || obs_we !== 1'b0 || obs_d !== 32'h1717) begin
      errors++; $display("FAIL stall_drain got ready=%b we3=%b wd3=%0h exp 0000/0/1717", obs_ready, obs_we, obs_d); end
  endtask

  task automatic test_hazard();
    s_valid[2] = 1; s_addr[2] = 5'd31; s_data[2] = 32'd3;
    run_cycle(0, 5'd31, 5'd9);
    checks++; if (obs_we !== 1'b1 || obs_a !== 5'd31 || obs_d !== 32'd3) begin errors++; $display("FAIL hz_write got we3=%b a3=%0d wd3=%0h exp 1/31/3", obs_we, obs_a, obs_d); end
    run_cycle(0, 5'd31, 5'd9);
    checks++; if (obs_hz1 !== 1'b1 || obs_hz2 !== 1'b0) begin errors++; $display("FAIL hz_active got hz1=%b hz2=%b exp 1/0", obs_hz1, obs_hz2); end
    run_cycle(0, 5'd31, 5'd9);
    checks++; if (obs_hz1 !== 1'b0 || obs_hz2 !== 1'b0) begin errors++; $display("FAIL hz_after got hz1=%b hz2=%b exp 0/0", obs_hz1, obs_hz2); end
  endtask

  task automatic test_reset_mid_write();
    s_valid[1] = 1; s_addr[1] = 5'd21; s_data[1] = 32'hBEEF;
    run_cycle(0, '0, '0);
    checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL midrst_pre got we3=%b exp 1", obs_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (we3 !== 1'b0 || a3 !== '0 || wd3 !== '0) begin errors++; $display("FAIL midrst_async got we3=%b a3=%0d wd3=%0h exp 0/0/0", we3, a3, wd3); end
    model_reset();
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      run_cycle(0, '0, '0);
      checks++; if (obs_we !== 1'b0 || obs_a !== '0 || obs_d !== '0) begin
        errors++; $display("FAIL midrst_idle[%0d] got we3=%b a3=%0d wd3=%0h exp 0/0/0", c, obs_we, obs_a, obs_d); end
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      logic [AW-1:0] ra1, ra2;
      bit st;
      for (int i = 0; i < NREQ; i++) begin
        if (!s_valid[i] && $urandom_range(1, 0) == 1) begin
          s_valid[i] = 1; s_addr[i] = AW'($urandom_range(31, 0)); s_data[i] = $urandom;
        end
      end
      st  = ($urandom_range(3, 0) == 0);
      ra1 = ($urandom_range(1, 0) == 1) ? m_a : AW'($urandom_range(31, 0));
      ra2 = ($urandom_range(1, 0) == 1) ? m_a : AW'($urandom_range(31, 0));
      run_cycle(st, ra1, ra2);
      checks++;
      if (obs_ready !== exp_ready || obs_hz1 !== exp_hz1 || obs_hz2 !== exp_hz2 ||
          obs_we !== m_we || obs_a !== m_a || obs_d !== m_d || obs_id !== m_id) begin
        errors++;
        if (bad < 10) $display("FAIL rand[%0d] got ready=%b hz=%b%b we3=%b a3=%0d wd3=%0h id=%0d exp ready=%b hz=%b%b we3=%b a3=%0d wd3=%0h id=%0d",
          c, obs_ready, obs_hz1, obs_hz2, obs_we, obs_a, obs_d, obs_id,
          exp_ready, exp_hz1, exp_hz2, m_we, m_a, m_d, m_id);
        bad++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin s_addr[i] = '0; s_data[i] = '0; end
    test_reset();
    test_round_robin();
    test_single();
    test_wrap_skip();
    test_stall();
    test_hazard();
    test_random();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
